// File: rtl/shift_tx.sv
// ---------------------------------------------------------------------------
// shift_tx
// Parallel-in / serial-out frame transmitter. A word captured on a start
// request in IDLE is sent LSB first, one bit per clock. It is optionally
// followed by an even-parity bit. A one-cycle done pulse marks the end of
// the frame.
//
// Compile-time option:
//   SHIFT_TX_PARITY_EN  when defined, a PARITY state appends the XOR of the
//                       captured word after the last data bit. When it is
//                       undefined, neither the state nor the parity logic
//                       exists.
//
// Parameters:
//   WIDTH       data bits per frame (2..32), default 8
//
// Ports:
//   clk         single clock, all state changes on the rising edge
//   reset       synchronous, active-high; overrides start and hold
//   data_in     [WIDTH-1:0] parallel word, sampled only at the capture edge
//   start       request to transmit data_in (honoured only in IDLE)
//   hold        freezes an ongoing frame (SHIFT/PARITY) while high
//   serial_out  registered serial line, idles at 1
//   busy        high while data/parity bits are on the line
//   done        one-cycle pulse after the last bit of a frame
// ---------------------------------------------------------------------------
module shift_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic             start,
  input  logic             hold,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  // One extra counter bit, so the counter can represent WIDTH without
  // wrapping for any legal WIDTH.
  localparam int              CNT_W    = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef SHIFT_TX_PARITY_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    DONE   = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    DONE   = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  // The bit currently on the line sits in serial_q. The shift register holds
  // only the bits still to come, so the register is WIDTH-1 bits wide.
  logic [WIDTH-2:0] shreg_q, shreg_d;
  logic             serial_q, serial_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SHIFT_TX_PARITY_EN
  // Parity is computed once from the captured word, so later changes to
  // data_in cannot disturb it.
  logic             parity_q, parity_d;
`endif

  // -------------------------------------------------------------------------
  // Next-state and next-output logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    shreg_d  = shreg_q;
    serial_d = serial_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
`ifdef SHIFT_TX_PARITY_EN
    parity_d = parity_q;
`endif

    unique case (state_q)
      IDLE: begin
        serial_d = 1'b1;
        busy_d   = 1'b0;
        if (start) begin
          // Bit 0 goes straight to the line register, so it is visible in
          // the cycle right after the capture edge.
          state_d  = SHIFT;
          cnt_d    = '0;
          shreg_d  = data_in[WIDTH-1:1];
          serial_d = data_in[0];
          busy_d   = 1'b1;
`ifdef SHIFT_TX_PARITY_EN
          parity_d = ^data_in;
`endif
        end
      end

      SHIFT: begin
        if (!hold) begin
          if (cnt_q == LAST_BIT) begin
`ifdef SHIFT_TX_PARITY_EN
            state_d  = PARITY;
            serial_d = parity_q;
            busy_d   = 1'b1;
`else
            state_d  = DONE;
            serial_d = 1'b1;
            busy_d   = 1'b0;
            done_d   = 1'b1;
`endif
          end else begin
            cnt_d    = cnt_q + CNT_W'(1);
            serial_d = shreg_q[0];
            shreg_d  = shreg_q >> 1;
          end
        end
      end

`ifdef SHIFT_TX_PARITY_EN
      PARITY: begin
        if (!hold) begin
          state_d  = DONE;
          serial_d = 1'b1;
          busy_d   = 1'b0;
          done_d   = 1'b1;
        end
      end
`endif

      DONE: begin
        // start and hold are ignored here. Back-to-back frames always pass
        // through IDLE.
        state_d  = IDLE;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end

      default: begin
        state_d  = IDLE;
        serial_d = 1'b1;
        busy_d   = 1'b0;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      shreg_q  <= '0;
      serial_q <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SHIFT_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      shreg_q  <= shreg_d;
      serial_q <= serial_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef SHIFT_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign serial_out = serial_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
